// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command arbiter: pin command encodings and arbiter states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_e;

  // True while one of the owners holds the command bus.
  function automatic logic state_is_busy(input state_e s);
    return (s == AREF) || (s == WRITE) || (s == READ);
  endfunction

endpackage

// File: rtl/sdram_arbit_wdog.sv
// Watchdog for an owner's tenure of the command bus: counts busy cycles, flags the last allowed one.
// Latency: expire_o is combinational from the count; it is high in the TIMEOUT_CYC-th busy cycle.
// Backpressure: none; clr_i forces the count to zero and has priority over run_i.
module sdram_arbit_wdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expire in the cycle the count reaches its last value while still running.
  assign expire_o = run_i && (cnt_q == CNT_LAST);

  // Next count: clear when idle, count while busy, hold at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// Central SDRAM command-bus arbiter: grants the pins to refresh, write or read after init.
// Latency: grant pulse one cycle after the request is seen in ARBIT; pin mux is combinational.
// Backpressure: wr/rd requests are level-held until granted; refresh pulses latch in ref_pend.
// Optional: define ARB_RR_EN for round-robin between write and read (refresh stays highest).
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int BA_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              flag_ref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              flag_wr_end,
  input  logic              flag_rd_end,
  input  logic [3:0]        wr_cmd,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [BA_W-1:0]   rd_ba,
  output logic              ref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic              err_timeout,
  output logic              err_ref_ovr
);

  state_e state_q, state_d;
  logic   ref_pend_q, ref_pend_d;
  logic   ref_en_q, wr_en_q, rd_en_q;
  logic   err_timeout_q, err_ref_ovr_q;

  logic   busy;
  logic   wdog_expire;
  logic   ref_req_acc;
  logic   ref_want;
  logic   wr_sel, rd_sel;
  logic   grant_ref, grant_wr, grant_rd;
  logic   timeout_hit;
  logic   ovr_hit;

  assign busy        = state_is_busy(state_q);
  // Refresh requests only count once init has handed over the bus.
  assign ref_req_acc = ref_req && (state_q != INIT);
  // A fresh pulse competes in the same cycle it arrives, so a refresh
  // arriving alongside write/read still wins without waiting a cycle.
  assign ref_want    = ref_pend_q || ref_req_acc;

`ifdef ARB_RR_EN
  logic last_wr_q;  // 1: last wr/rd grant went to write; reset value means read

  // Both pending: give the bus to whichever was not served last.
  always_comb begin
    wr_sel = wr_req && (!rd_req || !last_wr_q);
    rd_sel = rd_req && (!wr_req ||  last_wr_q);
  end

  // Remember which of write/read was granted most recently.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      last_wr_q <= 1'b0;
    end else if (grant_wr) begin
      last_wr_q <= 1'b1;
    end else if (grant_rd) begin
      last_wr_q <= 1'b0;
    end
  end
`else
  // Fixed priority: write ahead of read.
  always_comb begin
    wr_sel = wr_req;
    rd_sel = rd_req && !wr_req;
  end
`endif

  sdram_arbit_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk_i    (sclk),
    .rst_i    (s_rst),
    .clr_i    (!busy),
    .run_i    (busy),
    .expire_o (wdog_expire)
  );

  // Next state and grant decisions; end flag beats the watchdog in the same cycle.
  always_comb begin
    state_d     = state_q;
    grant_ref   = 1'b0;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      INIT: begin
        if (flag_init_end) state_d = ARBIT;
      end
      ARBIT: begin
        if (ref_want) begin
          grant_ref = 1'b1;
          state_d   = AREF;
        end else if (wr_sel) begin
          grant_wr  = 1'b1;
          state_d   = WRITE;
        end else if (rd_sel) begin
          grant_rd  = 1'b1;
          state_d   = READ;
        end
      end
      AREF: begin
        if (flag_ref_end) begin
          state_d = ARBIT;
        end else if (wdog_expire) begin
          state_d     = ARBIT;
          timeout_hit = 1'b1;
        end
      end
      WRITE: begin
        if (flag_wr_end) begin
          state_d = ARBIT;
        end else if (wdog_expire) begin
          state_d     = ARBIT;
          timeout_hit = 1'b1;
        end
      end
      READ: begin
        if (flag_rd_end) begin
          state_d = ARBIT;
        end else if (wdog_expire) begin
          state_d     = ARBIT;
          timeout_hit = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Pending refresh: a pulse consumed by its own grant does not linger, but a
  // second pulse landing on the grant edge stays latched; a pulse on top of an
  // un-served pending one is an overrun.
  always_comb begin
    ref_pend_d = ref_pend_q || ref_req_acc;
    ovr_hit    = 1'b0;
    if (grant_ref) begin
      ref_pend_d = ref_pend_q && ref_req_acc;
    end else if (ref_pend_q && ref_req_acc) begin
      ovr_hit = 1'b1;
    end
  end

  // State, pending refresh, one-cycle grant pulses and sticky error flags.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q       <= INIT;
      ref_pend_q    <= 1'b0;
      ref_en_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ref_ovr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_pend_q    <= ref_pend_d;
      ref_en_q      <= grant_ref;
      wr_en_q       <= grant_wr;
      rd_en_q       <= grant_rd;
      err_timeout_q <= err_timeout_q || timeout_hit;
      err_ref_ovr_q <= err_ref_ovr_q || ovr_hit;
    end
  end

  assign ref_en      = ref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign err_timeout = err_timeout_q;
  assign err_ref_ovr = err_ref_ovr_q;

  // Pin mux driven straight from the registered state: no extra latency.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    unique case (state_q)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_ba;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
      end
    endcase
  end

endmodule
